// File: rtl/bus_slave_ctrl.sv
// Bus slave access sequencer: decodes one of 8 slaves from the top address bits,
// runs a chip-select/strobe access with a ready timeout, and returns a one-cycle response.
module bus_slave_ctrl #(
   parameter int          ADDR_W   = 30,
   parameter int          DATA_W   = 32,
   parameter logic [7:0]  SLAVE_EN = 8'hFF,
   parameter int          TIMEOUT  = 255,
   parameter int          CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rest,
   input  logic                  req_valid,
   input  logic                  req_rw,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  busy,
   output logic [7:0]            s_cs,
   output logic                  s_as,
   output logic                  s_rw,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   input  logic [7:0]            s_rdy,
   input  logic [8*DATA_W-1:0]   s_rdata,
   output logic                  rsp_rdy,
   output logic                  rsp_err,
   output logic [DATA_W-1:0]     rsp_rdata
);

   // state    | meaning
   // S_IDLE   | waiting for req_valid
   // S_ACCESS | chip select + strobe driven, waiting for ready or timeout
   // S_NOMAP  | unmapped slave: one busy cycle with no chip select, then error
   // S_RESP   | one-cycle response pulse
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_NOMAP, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          idx_q, idx_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [2:0]          req_idx;

   assign req_idx = req_addr[ADDR_W-1 -: 3];

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               rw_d    = req_rw;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               idx_d   = req_idx;
               cnt_d   = '0;
               state_d = SLAVE_EN[req_idx] ? S_ACCESS : S_NOMAP;
            end
         end
         S_ACCESS: begin
            // ready is checked first so it wins over a same-cycle timeout
            if (s_rdy[idx_q]) begin
               rdata_d = rw_q ? '0 : s_rdata[int'(idx_q)*DATA_W +: DATA_W];
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NOMAP: begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      s_cs      = '0;
      s_as      = 1'b0;
      s_rw      = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      rsp_rdy   = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      if (state_q == S_ACCESS) begin
         s_cs    = 8'(1) << idx_q;
         s_as    = 1'b1;
         s_rw    = rw_q;
         s_addr  = addr_q;
         s_wdata = rw_q ? wdata_q : '0;
      end
      if (state_q == S_RESP) begin
         rsp_rdy   = 1'b1;
         rsp_err   = err_q;
         rsp_rdata = rdata_q;
      end
   end

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// Bench for bus_slave_ctrl: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level model.
module tb_bus_slave_ctrl;

   localparam int         AW  = 30;
   localparam int         DW  = 32;
   localparam logic [7:0] EN  = 8'h7F;
   localparam int         TMO = 4;

   logic            clk = 1'b0;
   logic            rest = 1'b0;
   logic            req_valid = 1'b0, req_rw = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [DW-1:0]   req_wdata = '0;
   logic            busy, s_as, s_rw, rsp_rdy, rsp_err;
   logic [7:0]      s_cs;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_wdata, rsp_rdata;
   logic [7:0]      s_rdy = '0;
   logic [8*DW-1:0] s_rdata = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bus_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SLAVE_EN(EN), .TIMEOUT(TMO), .CNT_W(3)) dut (
      .clk(clk), .rest(rest), .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(busy), .s_cs(s_cs), .s_as(s_as), .s_rw(s_rw),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdy(s_rdy), .s_rdata(s_rdata),
      .rsp_rdy(rsp_rdy), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   logic          m_txn, m_resp, m_mapped, m_rw, r_err;
   int            m_age, m_slave;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, r_data;

   always @(posedge clk or negedge rest) begin
      if (!rest) begin
         m_txn <= 1'b0; m_resp <= 1'b0; m_mapped <= 1'b0; m_rw <= 1'b0;
         r_err <= 1'b0; m_age <= 0; m_slave <= 0; m_addr <= '0; m_wdata <= '0; r_data <= '0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (m_txn) begin
         if (!m_mapped) begin
            m_txn <= 1'b0; m_resp <= 1'b1; r_err <= 1'b1; r_data <= '0;
         end else if (s_rdy[m_slave]) begin
            m_txn <= 1'b0; m_resp <= 1'b1; r_err <= 1'b0;
            r_data <= m_rw ? '0 : s_rdata[m_slave*DW +: DW];
         end else if (m_age == TMO) begin
            m_txn <= 1'b0; m_resp <= 1'b1; r_err <= 1'b1; r_data <= '0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (req_valid) begin
         m_txn    <= 1'b1;
         m_age    <= 1;
         m_rw     <= req_rw;
         m_addr   <= req_addr;
         m_wdata  <= req_wdata;
         m_slave  <= int'(req_addr / (1 << (AW-3)));
         m_mapped <= EN[int'(req_addr / (1 << (AW-3)))];
      end
   end

   logic          acc;
   logic [7:0]    e_cs;
   always_comb begin
      acc  = m_txn && m_mapped;
      e_cs = '0;
      if (acc) e_cs[m_slave] = 1'b1;
   end

   always @(negedge clk) begin
      chk("m_busy",  {63'd0, busy},    {63'd0, (m_txn || m_resp)});
      chk("m_cs",    {56'd0, s_cs},    {56'd0, e_cs});
      chk("m_as",    {63'd0, s_as},    {63'd0, acc});
      chk("m_rw",    {63'd0, s_rw},    {63'd0, acc && m_rw});
      chk("m_addr",  {34'd0, s_addr},  acc ? {34'd0, m_addr} : 64'd0);
      chk("m_wdata", {32'd0, s_wdata}, (acc && m_rw) ? {32'd0, m_wdata} : 64'd0);
      chk("m_rdy",   {63'd0, rsp_rdy}, {63'd0, m_resp});
      chk("m_err",   {63'd0, rsp_err}, {63'd0, m_resp && r_err});
      chk("m_rdata", {32'd0, rsp_rdata}, m_resp ? {32'd0, r_data} : 64'd0);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd;
      step();
      req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
   endtask

   initial begin
      #2;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_cs", {56'd0, s_cs}, 64'd0);
      chk("rst_rsp", {63'd0, rsp_rdy}, 64'd0);
      @(negedge clk); rest = 1'b1;
      step(); step();

      // read slave 2, ready on first ACCESS cycle
      s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
      s_rdata[3*DW +: DW] = 32'h5555_AAAA;
      issue(1'b0, 30'h1000_0010, 32'h0);
      s_rdy = 8'h04;
      chk("t1_cs", {56'd0, s_cs}, 64'h04);
      chk("t1_addr", {34'd0, s_addr}, 64'h1000_0010);
      chk("t1_norsp", {63'd0, rsp_rdy}, 64'd0);
      step(); s_rdy = 8'h00;
      chk("t1_rdy", {63'd0, rsp_rdy}, 64'd1);
      chk("t1_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
      chk("t1_err", {63'd0, rsp_err}, 64'd0);
      chk("t1_cs_off", {56'd0, s_cs}, 64'd0);
      step();
      chk("t1_idle", {63'd0, busy}, 64'd0);

      // write slave 5, ready after 3 wait cycles
      issue(1'b1, 30'h2800_0004, 32'h1234_5678);
      for (int i = 0; i < 4; i++) begin
         chk("t2_wdata", {32'd0, s_wdata}, 64'h1234_5678);
         chk("t2_cs", {56'd0, s_cs}, 64'h20);
         if (i == 3) s_rdy = 8'h20;
         step();
      end
      s_rdy = 8'h00;
      chk("t2_rdy", {63'd0, rsp_rdy}, 64'd1);
      chk("t2_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("t2_err", {63'd0, rsp_err}, 64'd0);
      step();

      // slave 1 never ready, other slave ready throughout: timeout after 4 cycles
      s_rdy = 8'h01;
      s_rdata[1*DW +: DW] = 32'hCAFE_F00D;
      issue(1'b0, 30'h0800_0000, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("t3_as", {63'd0, s_as}, 64'd1);
         step();
      end
      chk("t3_rdy", {63'd0, rsp_rdy}, 64'd1);
      chk("t3_err", {63'd0, rsp_err}, 64'd1);
      chk("t3_rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("t3_as_off", {63'd0, s_as}, 64'd0);
      step();

      // ready on the last allowed cycle wins over timeout
      issue(1'b0, 30'h0800_0000, 32'h0);
      step(); step(); step();
      s_rdy = 8'h03;
      step();
      s_rdy = 8'h00;
      chk("t4_rdy", {63'd0, rsp_rdy}, 64'd1);
      chk("t4_err", {63'd0, rsp_err}, 64'd0);
      chk("t4_rdata", {32'd0, rsp_rdata}, 64'hCAFE_F00D);
      step();

      // unmapped slave 7
      s_rdy = 8'h80;
      issue(1'b0, 30'h3800_0000, 32'h0);
      chk("t5_busy1", {63'd0, busy}, 64'd1);
      chk("t5_cs", {56'd0, s_cs}, 64'd0);
      chk("t5_norsp", {63'd0, rsp_rdy}, 64'd0);
      step();
      chk("t5_rdy", {63'd0, rsp_rdy}, 64'd1);
      chk("t5_err", {63'd0, rsp_err}, 64'd1);
      chk("t5_busy2", {63'd0, busy}, 64'd1);
      step();
      chk("t5_idle", {63'd0, busy}, 64'd0);
      s_rdy = 8'h00;

      // reset asserted mid-ACCESS
      issue(1'b1, 30'h1800_0000, 32'hA5A5_A5A5);
      #2 rest = 1'b0;
      #1;
      chk("t6_cs", {56'd0, s_cs}, 64'd0);
      chk("t6_as", {63'd0, s_as}, 64'd0);
      chk("t6_busy", {63'd0, busy}, 64'd0);
      @(negedge clk); rest = 1'b1;
      step();
      issue(1'b0, 30'h1800_0000, 32'h0);
      chk("t6_accept", {63'd0, busy}, 64'd1);
      chk("t6_cs3", {56'd0, s_cs}, 64'h08);
      step(); step(); step(); step(); step();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_rw    = 1'($urandom);
         req_addr  = 30'($urandom);
         req_wdata = $urandom;
         s_rdy     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         for (int i = 0; i < 8; i++) s_rdata[i*DW +: DW] = $urandom;
         if (c % 700 == 350) begin
            #3 rest = 1'b0;
            @(negedge clk); rest = 1'b1;
         end
         step();
      end
      req_valid = 1'b0; s_rdy = 8'h00;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
